// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU logic-unit constants: ALUFun codes, the BIST LFSR
//                feedback mask and the operand-B scramble mask, plus small
//                helpers used by the self-test engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Logic-unit function codes, shared with the ALU and control decoder
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;

  // Galois LFSR feedback mask (right-shifting form)
  localparam logic [31:0] c_lfsr_mask  = 32'h8020_0003;
  // Operand B is a half-swapped, scrambled copy of operand A
  localparam logic [31:0] c_b_scramble = 32'h5A5A_5A5A;

  // Number of ops exercised per run
  localparam logic [2:0] c_num_ops = 3'd5;

  // Op index (0..4) to ALUFun code
  function automatic logic [5:0] op_code(input logic [2:0] op);
    logic [5:0] code;
    case (op)
      3'd0:    code = ALU_AND;
      3'd1:    code = ALU_OR;
      3'd2:    code = ALU_XOR;
      3'd3:    code = ALU_NOR;
      3'd4:    code = ALU_A;
      default: code = 6'b000000;
    endcase
    return code;
  endfunction

  // One step of the right-shifting Galois LFSR
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_mask : 32'h0000_0000);
  endfunction

  // Derive operand B from operand A
  function automatic logic [31:0] scramble_b(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ c_b_scramble;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_logic_model.sv
`default_nettype none
// ============================================================================
//  Module      : alu_logic_model
//  Description : Combinational golden model of the ALU logic unit. Unknown
//                function codes produce zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_logic_model
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  output logic [31:0] expected
);

  // Reference result for the driven function code
  always_comb begin
    expected = 32'h0000_0000;
    case (ALUFun)
      ALU_AND: expected = A & B;
      ALU_OR:  expected = A | B;
      ALU_XOR: expected = A ^ B;
      ALU_NOR: expected = ~(A | B);
      ALU_A:   expected = A;
      default: expected = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_logic_bist.sv
`default_nettype none
// ============================================================================
//  Module      : alu_logic_bist
//  Description : Built-in self-test engine for the ALU logic unit. Streams
//                LFSR operand pairs through all five logic ops, one vector
//                per cycle, and checks the returned result against a golden
//                model. Reports pass/fail, error count and first failure.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_logic_bist
  import alu_pkg::*;
#(
  parameter int          N_VECTORS = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] S,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [5:0]  ALUFun,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [2:0]  fail_op,
  output logic [7:0]  fail_idx
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [7:0]  c_last_idx = 8'(N_VECTORS - 1);
  localparam logic [2:0]  c_last_op  = c_num_ops - 3'd1;
  localparam logic [15:0] c_err_max  = 16'hFFFF;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [7:0]  r_idx;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_alufun;
  logic [15:0] r_err;
  logic [2:0]  r_fail_op;
  logic [7:0]  r_fail_idx;
  logic        r_pass;

  logic [31:0] w_expected;
  logic        w_mismatch;
  logic        w_idx_wrap;
  logic        w_last_vec;
  logic [31:0] w_next_a;
  logic [2:0]  w_next_op;
  logic [7:0]  w_next_idx;

  alu_logic_model u_model (
    .A        (r_a),
    .B        (r_b),
    .ALUFun   (r_alufun),
    .expected (w_expected)
  );

  // Next-vector selection: step the LFSR within an op, reseed on op change
  always_comb begin
    w_mismatch = (S != w_expected);
    w_idx_wrap = (r_idx == c_last_idx);
    w_last_vec = w_idx_wrap && (r_op == c_last_op);
    w_next_a   = w_idx_wrap ? SEED : lfsr_step(r_a);
    w_next_op  = w_idx_wrap ? (r_op + 3'd1) : r_op;
    w_next_idx = w_idx_wrap ? 8'd0 : (r_idx + 8'd1);
  end

  // Run control, vector generation and result checking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_op       <= 3'd0;
      r_idx      <= 8'd0;
      r_a        <= 32'h0000_0000;
      r_b        <= 32'h0000_0000;
      r_alufun   <= 6'b000000;
      r_err      <= 16'h0000;
      r_fail_op  <= 3'b111;
      r_fail_idx <= 8'hFF;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state    <= c_st_run;
            r_op       <= 3'd0;
            r_idx      <= 8'd0;
            r_a        <= SEED;
            r_b        <= scramble_b(SEED);
            r_alufun   <= op_code(3'd0);
            r_err      <= 16'h0000;
            r_fail_op  <= 3'b111;
            r_fail_idx <= 8'hFF;
            r_pass     <= 1'b0;
          end
        end
        c_st_run: begin
          if (w_mismatch) begin
            if (r_err != c_err_max) begin
              r_err <= r_err + 16'd1;
            end
            // A zero count means this is the run's first mismatch
            if (r_err == 16'h0000) begin
              r_fail_op  <= r_op;
              r_fail_idx <= r_idx;
            end
          end
          if (w_last_vec) begin
            // Keep the final vector on the bus
            r_state <= c_st_done;
          end else begin
            r_op     <= w_next_op;
            r_idx    <= w_next_idx;
            r_a      <= w_next_a;
            r_b      <= scramble_b(w_next_a);
            r_alufun <= op_code(w_next_op);
          end
        end
        c_st_done: begin
          r_pass  <= (r_err == 16'h0000);
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign ALUFun    = r_alufun;
  assign busy      = (r_state == c_st_run);
  assign done      = (r_state == c_st_done);
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_op   = r_fail_op;
  assign fail_idx  = r_fail_idx;

endmodule
`default_nettype wire
